// File: rtl/fft_out_serializer.sv
// Serialises a 16-point complex FFT frame, delivered in parallel, into one
// sample per cycle using a valid/ready handshake on both sides. The frame is
// read out in natural bin order, and bit-reversed input is reordered here.
// Every output is derived only from registered state. The single
// combinational path is out_ready -> in_ready, which allows the next frame to
// be captured on the last beat without leaving a gap.
module fft_out_serializer #(
  parameter int DATA_WIDTH  = 20,
  parameter int BIT_REVERSE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH*16-1:0]     x_in_flat_real,
  input  logic [DATA_WIDTH*16-1:0]     x_in_flat_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic [3:0]                   out_index,
  output logic                         out_last
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]                   state;
  logic [3:0]                   k;
  logic [3:0]                   rd_idx;
  logic signed [DATA_WIDTH-1:0] frame_re [16];
  logic signed [DATA_WIDTH-1:0] frame_im [16];
  logic                         streaming;
  logic                         capture;
  logic                         advance;

  assign streaming = (state == STREAM);
  assign in_ready  = !streaming || ((k == 4'd15) && out_ready);
  assign capture   = in_valid && in_ready;
  assign advance   = streaming && out_ready;
  assign rd_idx    = (BIT_REVERSE != 0) ? {k[0], k[1], k[2], k[3]} : k;

  // Control FSM and bin counter. A new frame capture takes priority, so a
  // last-beat handshake that coincides with a capture stays in STREAM at k = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
    end else if (capture) begin
      state <= STREAM;
      k     <= '0;
    end else if (advance) begin
      if (k == 4'd15) begin
        state <= IDLE;
        k     <= '0;
      end else begin
        k <= k + 4'd1;
      end
    end
  end

  // Frame buffer. It loads only on an accepted frame, so it stays constant
  // while a frame is being streamed out.
  for (genvar g = 0; g < 16; g++) begin : g_buf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        frame_re[g] <= '0;
        frame_im[g] <= '0;
      end else if (capture) begin
        frame_re[g] <= x_in_flat_real[DATA_WIDTH*(16-g)-1 -: DATA_WIDTH];
        frame_im[g] <= x_in_flat_imag[DATA_WIDTH*(16-g)-1 -: DATA_WIDTH];
      end
    end
  end

  // Output mux. All outputs are forced to zero outside STREAM, and they hold
  // their values during a stall because k does not change.
  always_comb begin
    out_valid = streaming;
    out_real  = '0;
    out_imag  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (streaming) begin
      out_real  = frame_re[rd_idx];
      out_imag  = frame_im[rd_idx];
      out_index = k;
      out_last  = (k == 4'd15);
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer. It instantiates two copies that share
// all inputs: one reads the frame in bit-reversed order and one in natural
// order.
module tb_fft_out_serializer;

  localparam int DW = 20;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              out_ready;
  logic [DW*16-1:0]  x_re;
  logic [DW*16-1:0]  x_im;

  logic              in_ready,  in_ready_n;
  logic              out_valid, out_valid_n;
  logic signed [DW-1:0] out_real, out_real_n;
  logic signed [DW-1:0] out_imag, out_imag_n;
  logic [3:0]        out_index, out_index_n;
  logic              out_last,  out_last_n;

  int total;
  int passed;

  int nxt_re [16];
  int nxt_im [16];
  int cur_re [16];
  int cur_im [16];

  fft_out_serializer #(.DATA_WIDTH(DW), .BIT_REVERSE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in_flat_real(x_re), .x_in_flat_imag(x_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .out_last(out_last)
  );

  fft_out_serializer #(.DATA_WIDTH(DW), .BIT_REVERSE(0)) dut_nat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .x_in_flat_real(x_re), .x_in_flat_imag(x_im),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_real(out_real_n), .out_imag(out_imag_n),
    .out_index(out_index_n), .out_last(out_last_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed no finish, expected finish before 20000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  function automatic int bitrev(input int v);
    return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
  endfunction

  task automatic pack_next();
    for (int i = 0; i < 16; i++) begin
      x_re[DW*(16-i)-1 -: DW] = DW'(nxt_re[i]);
      x_im[DW*(16-i)-1 -: DW] = DW'(nxt_im[i]);
    end
  endtask

  task automatic load_frame_a();
    for (int i = 0; i < 16; i++) begin
      nxt_re[i] = i * 1000;
      nxt_im[i] = -i;
    end
    pack_next();
  endtask

  task automatic load_frame_b();
    for (int i = 0; i < 16; i++) begin
      nxt_re[i] = -524288 + i;
      nxt_im[i] = 524287;
    end
    pack_next();
  endtask

  task automatic take_next();
    for (int i = 0; i < 16; i++) begin
      cur_re[i] = nxt_re[i];
      cur_im[i] = nxt_im[i];
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_real"},  32'(out_real),  32'd0);
    check({tag, "_imag"},  32'(out_imag),  32'd0);
    check({tag, "_index"}, 32'(out_index), 32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
    check({tag, "_valid_nat"}, 32'(out_valid_n), 32'd0);
  endtask

  task automatic check_beat(input int k);
    check("beat_valid", 32'(out_valid), 32'd1);
    check("beat_index", 32'(out_index), 32'(k));
    check("beat_real",  32'(out_real),  32'(cur_re[bitrev(k)]));
    check("beat_imag",  32'(out_imag),  32'(cur_im[bitrev(k)]));
    check("beat_last",  32'(out_last),  32'(k == 15));
    check("nat_index",  32'(out_index_n), 32'(k));
    check("nat_real",   32'(out_real_n),  32'(cur_re[k]));
    check("nat_imag",   32'(out_imag_n),  32'(cur_im[k]));
    check("nat_last",   32'(out_last_n),  32'(k == 15));
  endtask

  // Present the next frame and let one rising edge capture it.
  task automatic start_frame();
    in_valid = 1'b1;
    #1 check("start_ready", 32'(in_ready), 32'd1);
    take_next();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Stream one frame, pulling out_ready low for stall_len cycles at bin
  // stall_at. If in_valid is high on the last beat, the next frame is taken.
  task automatic stream(input int stall_at, input int stall_len);
    int k;
    int stall;
    bit chained;
    k = 0;
    stall = 0;
    chained = 1'b0;
    while (k < 16) begin
      out_ready = !(k == stall_at && stall < stall_len);
      #1;
      check_beat(k);
      check("ready_pulse", 32'(in_ready), 32'(k == 15 && out_ready));
      if (!out_ready) stall++;
      else begin
        if (k == 15 && in_valid) chained = 1'b1;
        k++;
      end
      @(negedge clk);
    end
    if (chained) begin
      take_next();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
  endtask

  int hand_re [4];
  int hand_im [4];

  initial begin
    total = 0;
    passed = 0;
    hand_re = '{0, 8000, 4000, 12000};
    hand_im = '{0, -8, -4, -12};
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x_re = '0;
    x_im = '0;
    #1 check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_idle("post_reset");

    // Frame A at full rate, with hand-computed anchors for the bit-reversed order.
    load_frame_a();
    start_frame();
    x_re = '1;
    x_im = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("hand_real", 32'(out_real), 32'(hand_re[k]));
      check("hand_imag", 32'(out_imag), 32'(hand_im[k]));
      check("hand_index", 32'(out_index), 32'(k));
      @(negedge clk);
    end
    for (int k = 4; k < 16; k++) begin
      #1 check_beat(k);
      if (k == 15) begin
        check("beat15_real", 32'(out_real), 32'd15000);
        check("beat15_imag", 32'(out_imag), -32'sd15);
        check("beat15_last", 32'(out_last), 32'd1);
      end
      @(negedge clk);
    end
    #1 check_idle("after_a");

    // Stall at bin 5 for three cycles.
    @(negedge clk);
    load_frame_a();
    start_frame();
    stream(5, 3);
    #1 check_idle("after_stall");

    // Back-to-back: frame B waits with in_valid high while A streams.
    @(negedge clk);
    load_frame_a();
    in_valid = 1'b1;
    #1 check("b2b_ready", 32'(in_ready), 32'd1);
    take_next();
    @(negedge clk);
    load_frame_b();
    in_valid = 1'b1;
    stream(-1, 0);
    stream(-1, 0);
    #1 check_idle("after_b2b");

    // Asynchronous reset in the middle of a frame, while streaming bin 7.
    @(negedge clk);
    load_frame_a();
    start_frame();
    for (int k = 0; k < 7; k++) begin
      #1 check_beat(k);
      @(negedge clk);
    end
    #1 check_beat(7);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_idle("reset_release");
    @(negedge clk);
    #1 check_idle("reset_quiet");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
